// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the multicycle CPU controller.
// States, instruction class/control opcodes and ALU op type.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    typedef logic [2:0] alu_op_t;

    localparam logic [1:0] CLS_RALU = 2'b00;
    localparam logic [1:0] CLS_IALU = 2'b01;
    localparam logic [1:0] CLS_MEM  = 2'b10;
    localparam logic [1:0] CLS_CTRL = 2'b11;

    localparam logic [1:0] CT_JMP  = 2'b00;
    localparam logic [1:0] CT_BZ   = 2'b01;
    localparam logic [1:0] CT_BNZ  = 2'b10;
    localparam logic [1:0] CT_HALT = 2'b11;

    localparam alu_op_t ALU_NOP = 3'b000;

    function automatic logic is_alu_class(input logic [1:0] cls);
        return !cls[1];
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multicycle controller: sequences fetch/decode/exec/mem/wb over a
// single shared memory port, with a memory wait timeout into ERR.
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic        pc_sel,
    output logic        reg_ld,
    output logic        wb_sel,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        halted,
    output logic        err
);

    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cls;
    logic [1:0]       ctl;
    logic             taken;
    logic             unused_bits;

    assign cls = instr[18:17];
    assign ctl = instr[16:15];
    // Address and immediate fields feed the datapath, not the controller.
    assign unused_bits = &{1'b0, instr[13:0]};

    // State sequencing and memory wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        cnt   <= '0;
                        state <= S_DECODE;
                    end else if (cnt == TO) begin
                        state <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    cnt <= '0;
                    if (is_alu_class(cls))
                        state <= S_EXEC;
                    else if (cls == CLS_MEM)
                        state <= S_MEM;
                    else if (ctl == CT_HALT)
                        state <= S_HALT;
                    else
                        state <= S_FETCH;
                end
                S_EXEC: state <= S_WB;
                S_WB: begin
                    cnt   <= '0;
                    state <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        cnt   <= '0;
                        state <= S_FETCH;
                    end else if (cnt == TO) begin
                        state <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HALT: state <= S_HALT;
                S_ERR:  state <= S_ERR;
                default: state <= S_ERR;
            endcase
        end
    end

    // Datapath controls decoded from state, IR and flags.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_ld    = 1'b0;
        pc_ld    = 1'b0;
        pc_sel   = 1'b0;
        reg_ld   = 1'b0;
        wb_sel   = 1'b0;
        alu_src  = 1'b0;
        alu_op   = ALU_NOP;
        halted   = 1'b0;
        err      = 1'b0;
        taken    = 1'b0;
        if (!rst) begin
            unique case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_ld = 1'b1;
                        pc_ld = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (cls == CLS_CTRL) begin
                        unique case (ctl)
                            CT_JMP:  taken = 1'b1;
                            CT_BZ:   taken = zero;
                            CT_BNZ:  taken = !zero;
                            default: taken = 1'b0;
                        endcase
                    end
                    pc_ld  = taken;
                    pc_sel = taken;
                end
                S_EXEC: begin
                    alu_op  = instr[16:14];
                    alu_src = (cls == CLS_IALU);
                end
                S_WB: begin
                    alu_op  = instr[16:14];
                    alu_src = (cls == CLS_IALU);
                    reg_ld  = 1'b1;
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = instr[16];
                    if (mem_ready && !instr[16]) begin
                        reg_ld = 1'b1;
                        wb_sel = 1'b1;
                    end
                end
                S_HALT: halted = 1'b1;
                S_ERR: begin
                    halted = 1'b1;
                    err    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Outputs packed into one vector and compared per cycle.
module tb_multicycle_controller;

    logic        clk;
    logic        rst;
    logic [18:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_ld, pc_ld, pc_sel;
    logic        reg_ld, wb_sel, alu_src, halted, err;
    logic [2:0]  alu_op;
    logic [13:0] outs;

    int n_cmp;
    int n_bad;

    // {mem_req,mem_we,addr_sel,ir_ld,pc_ld,pc_sel,reg_ld,wb_sel,alu_src,alu_op,halted,err}
    localparam logic [13:0] O_ZERO  = 14'b0_0_0_0_0_0_0_0_0_000_0_0;
    localparam logic [13:0] O_FREQ  = 14'b1_0_0_0_0_0_0_0_0_000_0_0;
    localparam logic [13:0] O_FDONE = 14'b1_0_0_1_1_0_0_0_0_000_0_0;
    localparam logic [13:0] O_EX010 = 14'b0_0_0_0_0_0_0_0_0_010_0_0;
    localparam logic [13:0] O_WB010 = 14'b0_0_0_0_0_0_1_0_0_010_0_0;
    localparam logic [13:0] O_EXI   = 14'b0_0_0_0_0_0_0_0_1_101_0_0;
    localparam logic [13:0] O_WBI   = 14'b0_0_0_0_0_0_1_0_1_101_0_0;
    localparam logic [13:0] O_LDW   = 14'b1_0_1_0_0_0_0_0_0_000_0_0;
    localparam logic [13:0] O_LDOK  = 14'b1_0_1_0_0_0_1_1_0_000_0_0;
    localparam logic [13:0] O_STOK  = 14'b1_1_1_0_0_0_0_0_0_000_0_0;
    localparam logic [13:0] O_BR    = 14'b0_0_0_0_1_1_0_0_0_000_0_0;
    localparam logic [13:0] O_HALT  = 14'b0_0_0_0_0_0_0_0_0_000_1_0;
    localparam logic [13:0] O_ERR   = 14'b0_0_0_0_0_0_0_0_0_000_1_1;

    assign outs = {mem_req, mem_we, addr_sel, ir_ld, pc_ld, pc_sel,
                   reg_ld, wb_sel, alu_src, alu_op, halted, err};

    multicycle_controller dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_ld     (ir_ld),
        .pc_ld     (pc_ld),
        .pc_sel    (pc_sel),
        .reg_ld    (reg_ld),
        .wb_sel    (wb_sel),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .halted    (halted),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [13:0] got,
                       input logic [13:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, check at negedge, advance past posedge.
    task automatic tick(input string tag, input logic rdy, input logic z,
                        input logic [13:0] exp);
        mem_ready = rdy;
        zero      = z;
        @(negedge clk);
        chk(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_hold", outs, O_ZERO);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        instr     = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        tick("fetch_after_rst", 1'b0, 1'b0, O_FREQ);

        // Reset in the middle of a fetch drops mem_req at once.
        rst = 1'b1;
        #1;
        chk("rst_mid_fetch", outs, O_ZERO);
        @(posedge clk);
        #1;
        chk("rst_mid_edge", outs, O_ZERO);
        rst = 1'b0;
        tick("fetch_release", 1'b0, 1'b0, O_FREQ);

        // R-ALU op 010
        instr = {2'b00, 3'b010, 14'h0};
        tick("ralu_fetch", 1'b1, 1'b0, O_FDONE);
        tick("ralu_dec",   1'b0, 1'b0, O_ZERO);
        tick("ralu_exec",  1'b0, 1'b0, O_EX010);
        tick("ralu_wb",    1'b0, 1'b0, O_WB010);
        tick("ralu_next",  1'b0, 1'b0, O_FREQ);

        // I-ALU op 101
        instr = {2'b01, 3'b101, 14'h0};
        tick("ialu_fetch", 1'b1, 1'b0, O_FDONE);
        tick("ialu_dec",   1'b0, 1'b0, O_ZERO);
        tick("ialu_exec",  1'b0, 1'b0, O_EXI);
        tick("ialu_wb",    1'b0, 1'b0, O_WBI);

        // LD from 0x0A5 with three wait cycles
        instr = {2'b10, 1'b0, 4'h0, 12'h0A5};
        tick("ld_fetch", 1'b1, 1'b0, O_FDONE);
        tick("ld_dec",   1'b0, 1'b0, O_ZERO);
        for (int i = 0; i < 3; i++)
            tick("ld_wait", 1'b0, 1'b0, O_LDW);
        tick("ld_done",  1'b1, 1'b0, O_LDOK);
        tick("ld_next",  1'b0, 1'b0, O_FREQ);

        // ST, zero-wait memory
        instr = {2'b10, 1'b1, 4'h0, 12'h3C3};
        tick("st_fetch", 1'b1, 1'b0, O_FDONE);
        tick("st_dec",   1'b0, 1'b0, O_ZERO);
        tick("st_done",  1'b1, 1'b0, O_STOK);
        tick("st_next",  1'b0, 1'b0, O_FREQ);

        // BZ not taken, then taken
        instr = {2'b11, 2'b01, 15'h0};
        tick("bz_fetch", 1'b1, 1'b0, O_FDONE);
        tick("bz_nt",    1'b0, 1'b0, O_ZERO);
        tick("bz_fetch", 1'b1, 1'b1, O_FDONE);
        tick("bz_t",     1'b0, 1'b1, O_BR);
        tick("bz_next",  1'b0, 1'b0, O_FREQ);

        // BNZ taken on zero==0, JMP always
        instr = {2'b11, 2'b10, 15'h0};
        tick("bnz_fetch", 1'b1, 1'b0, O_FDONE);
        tick("bnz_t",     1'b0, 1'b0, O_BR);
        tick("bnz_fetch", 1'b1, 1'b1, O_FDONE);
        tick("bnz_nt",    1'b0, 1'b1, O_ZERO);
        instr = {2'b11, 2'b00, 15'h0};
        tick("jmp_fetch", 1'b1, 1'b0, O_FDONE);
        tick("jmp_t",     1'b0, 1'b1, O_BR);

        // Ready arriving in the counter==TIMEOUT cycle still wins
        for (int i = 0; i < 15; i++)
            tick("to_win_wait", 1'b0, 1'b0, O_FREQ);
        tick("to_win_done", 1'b1, 1'b0, O_FDONE);
        tick("to_win_dec",  1'b0, 1'b0, O_BR);

        // Timeout into ERR, sticky
        for (int i = 0; i < 16; i++)
            tick("to_wait", 1'b0, 1'b0, O_FREQ);
        tick("to_err", 1'b0, 1'b0, O_ERR);
        for (int i = 0; i < 4; i++)
            tick("err_sticky", 1'b1, 1'b0, O_ERR);
        do_reset();
        tick("err_cleared", 1'b0, 1'b0, O_FREQ);

        // HALT is sticky and never requests memory
        instr = {2'b11, 2'b11, 15'h0};
        tick("halt_fetch", 1'b1, 1'b0, O_FDONE);
        tick("halt_dec",   1'b0, 1'b0, O_ZERO);
        for (int i = 0; i < 20; i++)
            tick("halt_hold", i[0], 1'b0, O_HALT);
        do_reset();
        tick("halt_cleared", 1'b0, 1'b0, O_FREQ);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
